// File: rtl/adder_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_disp_pkg
//  Purpose  : Shared definitions for the adder sequencing/display controller:
//             FSM state encoding, digit slot indices and the anode pattern
//             that lights each slot.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package adder_disp_pkg;

  // Load/capture sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Digit slot indices (0 = rightmost digit)
  localparam logic [1:0] DIG_SUM = 2'd0;
  localparam logic [1:0] DIG_CO  = 2'd1;
  localparam logic [1:0] DIG_B   = 2'd2;
  localparam logic [1:0] DIG_A   = 2'd3;

  // Active-low anode patterns
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_SUM = 4'b1110;
  localparam logic [3:0] AN_CO  = 4'b1101;
  localparam logic [3:0] AN_B   = 4'b1011;
  localparam logic [3:0] AN_A   = 4'b0111;

  // Anode pattern for a digit slot; always exactly one anode low.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      DIG_SUM: pat = AN_SUM;
      DIG_CO:  pat = AN_CO;
      DIG_B:   pat = AN_B;
      default: pat = AN_A;
    endcase
    return pat;
  endfunction

endpackage : adder_disp_pkg
`default_nettype wire

// File: rtl/disp_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scanner
//  Purpose  : Time-multiplexes four latched values across the four
//             seven-segment digits. A free-running refresh counter sets the
//             slot length; on each wrap the digit index advances 0->1->2->3.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             disp_sum/co/b/a       - latched values to display
//             an                    - anodes, active-low (1111 only in reset)
//             digit_val             - hex value for the bcd7seg decoder
//  Revision : 1.0 - initial release
// ============================================================================
module disp_scanner
  import adder_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] disp_sum,
  input  logic       disp_co,
  input  logic [3:0] disp_b,
  input  logic [3:0] disp_a,
  output logic [3:0] an,
  output logic [3:0] digit_val
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [1:0]    idx_next;
  logic          wrap;
  logic [3:0]    val_next;

  // an and digit_val are both derived from the index the slot is about to
  // hold, so they change on the same edge and never pair a new anode with
  // the previous digit's value.
  always_comb begin
    wrap     = (refresh_cnt == CNT_LAST);
    idx_next = wrap ? digit_idx + 2'd1 : digit_idx;
    case (idx_next)
      DIG_SUM: val_next = disp_sum;
      DIG_CO:  val_next = {3'b000, disp_co};
      DIG_B:   val_next = disp_b;
      default: val_next = disp_a;
    endcase
  end

  // digit_val is reloaded every cycle, so a freshly captured value reaches
  // the display one cycle after it is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= DIG_SUM;
      an          <= AN_OFF;
      digit_val   <= 4'h0;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + CW'(1);
      digit_idx   <= idx_next;
      an          <= anode_for(idx_next);
      digit_val   <= val_next;
    end
  end

endmodule : disp_scanner
`default_nettype wire

// File: rtl/adder_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adder_scan_ctrl
//  Purpose  : Sequencing and display controller for the 4-bit adder.
//             Synchronizes the load button, captures the operand switches on
//             its rising edge, holds them on the external adder for a settle
//             window, then registers SUM/CO. The scanner shows SUM, CO, B
//             and A across the four seven-segment digits.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             sw_a, sw_b, sw_ci      - operand switches
//             btn_load               - load button (asynchronous)
//             add_a, add_b, add_ci   - operands driven to the adder
//             add_sum, add_co        - adder result
//             busy                   - load sequence in progress
//             res_valid              - one-cycle pulse on result capture
//             digit_val, an          - display value and active-low anodes
//  Revision : 1.0 - initial release
// ============================================================================
module adder_scan_ctrl
  import adder_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic       sw_ci,
  input  logic       btn_load,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_ci,
  input  logic [3:0] add_sum,
  input  logic       add_co,
  output logic       busy,
  output logic       res_valid,
  output logic [3:0] digit_val,
  output logic [3:0] an
);

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Load button synchronizer and rising-edge detector
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   load_prev;
  logic                   load_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync <= '0;
      load_prev <= 1'b0;
    end else begin
      load_sync <= {load_sync[SYNC_STAGES-2:0], btn_load};
      load_prev <= load_sync[SYNC_STAGES-1];
    end
  end

  assign load_pulse = load_sync[SYNC_STAGES-1] & ~load_prev;

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [SW-1:0] settle_cnt;
  logic          load_accept;
  logic          capture_en;

  // Loads are only accepted in IDLE; a pulse arriving in any other state is
  // dropped rather than queued.
  always_comb begin
    state_next  = state;
    load_accept = 1'b0;
    capture_en  = 1'b0;
    res_valid   = 1'b0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (load_pulse) begin
          load_accept = 1'b1;
          state_next  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
        res_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (load_accept) begin
      settle_cnt <= '0;
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Operand and result registers
  // --------------------------------------------------------------------------
  logic [3:0] disp_a;
  logic [3:0] disp_b;
  logic [3:0] disp_sum;
  logic       disp_co;

  // Operands go to the adder and to the display latches together; add_*
  // then hold their value until the next accepted load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a  <= 4'h0;
      add_b  <= 4'h0;
      add_ci <= 1'b0;
      disp_a <= 4'h0;
      disp_b <= 4'h0;
    end else if (load_accept) begin
      add_a  <= sw_a;
      add_b  <= sw_b;
      add_ci <= sw_ci;
      disp_a <= sw_a;
      disp_b <= sw_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_sum <= 4'h0;
      disp_co  <= 1'b0;
    end else if (capture_en) begin
      disp_sum <= add_sum;
      disp_co  <= add_co;
    end
  end

  // --------------------------------------------------------------------------
  // Display scanner
  // --------------------------------------------------------------------------
  disp_scanner #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_sum  (disp_sum),
    .disp_co   (disp_co),
    .disp_b    (disp_b),
    .disp_a    (disp_a),
    .an        (an),
    .digit_val (digit_val)
  );

endmodule : adder_scan_ctrl
`default_nettype wire

// File: tb/tb_adder_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_adder_scan_ctrl
//  Purpose  : Self-checking bench for adder_scan_ctrl with a behavioural
//             ripple adder attached. Expected results are pushed to a
//             scoreboard queue when a load is driven and popped on res_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_scan_ctrl;

  localparam int REFRESH_DIV   = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int SYNC_STAGES   = 2;
  // btn_load driven just before edge 1: sync(2) -> pulse, settle(2), capture
  localparam int LOAD_LATENCY  = SYNC_STAGES + SETTLE_CYCLES + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_a = 4'h0;
  logic [3:0] sw_b = 4'h0;
  logic       sw_ci = 1'b0;
  logic       btn_load = 1'b0;
  logic [3:0] add_a, add_b, add_sum, digit_val, an;
  logic       add_ci, add_co, busy, res_valid;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       co;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Behavioural ripple adder
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_ci};

  adder_scan_ctrl #(
    .REFRESH_DIV   (REFRESH_DIV),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_a      (sw_a),
    .sw_b      (sw_b),
    .sw_ci     (sw_ci),
    .btn_load  (btn_load),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_sum   (add_sum),
    .add_co    (add_co),
    .busy      (busy),
    .res_valid (res_valid),
    .digit_val (digit_val),
    .an        (an)
  );

  function automatic logic [3:0] slot_anode(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [3:0] a, input logic [3:0] b, input logic ci);
    exp_t e;
    logic [4:0] s;
    s     = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    e.a   = a;
    e.b   = b;
    e.sum = s[3:0];
    e.co  = s[4];
    return e;
  endfunction

  // Pop the scoreboard on a capture and compare the adder-side result.
  task automatic pop_and_check(input string name);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: res_valid with no expected entry", name);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      if ({add_co, add_sum, add_a, add_b} !== {e.co, e.sum, e.a, e.b}) begin
        fails++;
        $display("FAIL %s capture: got co=%0b sum=%h a=%h b=%h, expected co=%0b sum=%h a=%h b=%h",
                 name, add_co, add_sum, add_a, add_b, e.co, e.sum, e.a, e.b);
      end
    end
  endtask

  // Watch the display for a full scan and check each slot's value.
  task automatic check_display(input exp_t e, input string name);
    logic [3:0] exp_v;
    for (int c = 0; c < 4 * REFRESH_DIV; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: exp_v = e.sum;
        4'b1101: exp_v = {3'b000, e.co};
        4'b1011: exp_v = e.b;
        4'b0111: exp_v = e.a;
        default: exp_v = 4'hx;
      endcase
      tests++;
      if ($isunknown(exp_v) || digit_val !== exp_v) begin
        fails++;
        $display("FAIL %s display: an=%b digit_val=%h, expected %h", name, an, digit_val, exp_v);
      end
    end
  endtask

  // Drive a load with btn_load held for 'hold' cycles; expects exactly one
  // capture at LOAD_LATENCY, then checks the display.
  task automatic run_load(input logic [3:0] a, input logic [3:0] b, input logic ci,
                          input int hold, input string name);
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    sb.push_back(make_exp(a, b, ci));
    sw_a = a; sw_b = b; sw_ci = ci; btn_load = 1'b1;
    for (int c = 1; c <= hold + 20; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = c;
          pop_and_check(name);
        end
      end
      if (c == hold) btn_load = 1'b0;
    end
    tests++;
    if (pulses != 1 || first != LOAD_LATENCY) begin
      fails++;
      $display("FAIL %s res_valid: %0d pulses first at cycle %0d, expected 1 pulse at cycle %0d",
               name, pulses, first, LOAD_LATENCY);
    end
    check_display(last_exp, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_load = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({an, digit_val, busy, res_valid, add_a, add_b, add_ci} !== {4'b1111, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: an=%b digit_val=%h busy=%b res_valid=%b add=%h/%h/%b, expected 1111 0 0 0 0/0/0",
               an, digit_val, busy, res_valid, add_a, add_b, add_ci);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 8 * REFRESH_DIV; n++) begin
      @(negedge clk);
      tests++;
      if (an !== slot_anode((n / REFRESH_DIV) % 4) || digit_val !== 4'h0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL scan_idle cycle %0d: an=%b digit_val=%h busy=%b, expected an=%b digit_val=0 busy=0",
                 n, an, digit_val, busy, slot_anode((n / REFRESH_DIV) % 4));
      end
    end
  endtask

  task automatic test_basic_add();
    run_load(4'h5, 4'h3, 1'b0, 10, "add_5_3");
  endtask

  task automatic test_carry_and_hold();
    run_load(4'hF, 4'h1, 1'b1, 3, "add_F_1_1");
    sw_a = 4'h0; sw_b = 4'h0; sw_ci = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if ({add_a, add_b, add_ci, busy, res_valid} !== {4'hF, 4'h1, 1'b1, 2'b00}) begin
      fails++;
      $display("FAIL switch_hold: add=%h/%h/%b busy=%b res_valid=%b, expected F/1/1 0 0",
               add_a, add_b, add_ci, busy, res_valid);
    end
    check_display(last_exp, "switch_hold");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    sb.push_back(make_exp(4'h2, 4'h7, 1'b1));
    sw_a = 4'h2; sw_b = 4'h7; sw_ci = 1'b1; btn_load = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = c;
          pop_and_check("back_to_back");
        end
      end
      if (c == 2) btn_load = 1'b0;
      if (c == 3) begin
        sw_a = 4'h9; sw_b = 4'h9; sw_ci = 1'b0; btn_load = 1'b1;
      end
      if (c == 10) btn_load = 1'b0;
    end
    tests++;
    if (pulses != 1 || first != LOAD_LATENCY || sb.size() != 0) begin
      fails++;
      $display("FAIL back_to_back res_valid: %0d pulses first at %0d, %0d pending, expected 1 at %0d, 0 pending",
               pulses, first, sb.size(), LOAD_LATENCY);
    end
    tests++;
    if ({add_a, add_b, add_ci} !== {4'h2, 4'h7, 1'b1}) begin
      fails++;
      $display("FAIL back_to_back operands: add=%h/%h/%b, expected 2/7/1", add_a, add_b, add_ci);
    end
    check_display(last_exp, "back_to_back");
  endtask

  // Time the load so the capture cycle is the last cycle of slot 3; the
  // next edge moves the scan to the SUM slot.
  task automatic test_digit_advance();
    logic [3:0] old_sum;
    exp_t       e;
    int         guard;
    old_sum = last_exp.sum;
    e       = make_exp(4'h6, 4'h1, 1'b0);
    btn_load = 1'b0;
    guard = 0;
    while (an === 4'b1011 && guard < 40) begin @(negedge clk); guard++; end
    while (an !== 4'b1011 && guard < 40) begin @(negedge clk); guard++; end
    tests++;
    if (guard >= 40) begin
      fails++;
      $display("FAIL digit_adv sync: an=%b never reached 1011", an);
    end
    repeat (2) @(negedge clk);
    sb.push_back(e);
    sw_a = e.a; sw_b = e.b; sw_ci = 1'b0; btn_load = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == LOAD_LATENCY) begin
        tests++;
        if (res_valid !== 1'b1 || an !== 4'b0111) begin
          fails++;
          $display("FAIL digit_adv capture: res_valid=%b an=%b, expected 1 0111", res_valid, an);
        end
        if (res_valid === 1'b1) pop_and_check("digit_adv");
      end
      if (c == LOAD_LATENCY + 1) begin
        tests++;
        if (an !== 4'b1110 || (digit_val !== old_sum && digit_val !== e.sum)) begin
          fails++;
          $display("FAIL digit_adv first: an=%b digit_val=%h, expected 1110 with %h or %h",
                   an, digit_val, old_sum, e.sum);
        end
      end
      if (c == LOAD_LATENCY + 2) begin
        tests++;
        if (an !== 4'b1110 || digit_val !== e.sum) begin
          fails++;
          $display("FAIL digit_adv settled: an=%b digit_val=%h, expected 1110 %h", an, digit_val, e.sum);
        end
      end
      if (c == 8) btn_load = 1'b0;
    end
    check_display(e, "digit_adv");
  endtask

  task automatic test_reset_mid_settle();
    sb.push_back(make_exp(4'hC, 4'h3, 1'b1));
    sw_a = 4'hC; sw_b = 4'h3; sw_ci = 1'b1; btn_load = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || add_a !== 4'hC) begin
      fails++;
      $display("FAIL reset_mid pre: busy=%b add_a=%h, expected 1 C", busy, add_a);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({an, digit_val, busy, res_valid, add_a, add_b, add_ci} !== {4'b1111, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid async: an=%b digit_val=%h busy=%b res_valid=%b add=%h/%h/%b, expected 1111 0 0 0 0/0/0",
               an, digit_val, busy, res_valid, add_a, add_b, add_ci);
    end
    sb.delete();
    btn_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tests++;
      if (res_valid !== 1'b0 || digit_val !== 4'h0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid after cycle %0d: res_valid=%b digit_val=%h busy=%b, expected 0 0 0",
                 c, res_valid, digit_val, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_and_hold();
    test_back_to_back();
    test_digit_advance();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_adder_scan_ctrl
`default_nettype wire
